// File: rtl/mouse_tracker.sv
// mouse_tracker: PS/2 mouse front end for the counter sandbox.
// Receives PS/2 frames, assembles 3-byte packets, accumulates X movement
// into an absolute 16-bit position and tracks the left button.
//
// Ports:
//   i_clock          system clock (only clock domain)
//   i_reset_         asynchronous active-high reset
//   i_ps2_clk        raw PS/2 clock (asynchronous)
//   i_ps2_data       raw PS/2 data  (asynchronous)
//   o_mouse_x        absolute X position
//   o_mouse_pressed_ left button, active-low (0 = held)
//   o_packet_valid   one-cycle pulse when a packet has been applied
//   o_frame_error    one-cycle pulse on parity, stop-bit or timeout error
//
// Build option: define MOUSE_TRACKER_CLAMP_EN to saturate X to 0..X_MAX;
// otherwise X wraps modulo 2^16.
module mouse_tracker #(
  parameter logic [15:0] X_MAX   = 16'd639,
  parameter logic [15:0] X_RESET = 16'd0,
  parameter int          TIMEOUT = 4096
) (
  input  logic        i_clock,
  input  logic        i_reset_,
  input  logic        i_ps2_clk,
  input  logic        i_ps2_data,
  output logic [15:0] o_mouse_x,
  output logic        o_mouse_pressed_,
  output logic        o_packet_valid,
  output logic        o_frame_error
);

  localparam int             CW          = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  TIMEOUT_CNT = CW'(TIMEOUT);

`ifdef MOUSE_TRACKER_CLAMP_EN
  localparam logic CLAMP_EN = 1'b1;
`else
  localparam logic CLAMP_EN = 1'b0;
`endif

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  // Odd parity over data + parity bit holds when the XOR of all nine is 1.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  logic          r_clk_s1, r_clk_s2, r_clk_s3;
  logic          r_dat_s1, r_dat_s2;
  logic [1:0]    r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [1:0]    r_byte_idx;
  logic          r_btn, r_sign, r_ovf;
  logic [7:0]    r_dx;
  logic [CW-1:0] r_idle_cnt;

  logic          w_fall;
  logic          w_bit;
  logic          w_timeout;
  logic [16:0]   w_delta;
  logic [16:0]   w_sum;
  logic [15:0]   w_next_x;

  // Two-flop synchronisers plus a third clock flop for falling-edge detection.
  always_ff @(posedge i_clock or posedge i_reset_) begin
    if (i_reset_) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_clk_s3 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= i_ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_clk_s3 <= r_clk_s2;
      r_dat_s1 <= i_ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  assign w_fall    = r_clk_s3 & ~r_clk_s2;
  assign w_bit     = r_dat_s2;
  // A falling edge in the same cycle takes priority and reloads the counter.
  assign w_timeout = (r_state != ST_IDLE) && !w_fall && (r_idle_cnt == TIMEOUT_CNT);

  // Idle counter: reloads on each PS/2 clock fall, saturates at TIMEOUT.
  always_ff @(posedge i_clock or posedge i_reset_) begin
    if (i_reset_) begin
      r_idle_cnt <= {CW{1'b0}};
    end else if (w_fall) begin
      r_idle_cnt <= {CW{1'b0}};
    end else if (r_idle_cnt != TIMEOUT_CNT) begin
      r_idle_cnt <= r_idle_cnt + CW'(1);
    end else begin
      r_idle_cnt <= r_idle_cnt;
    end
  end

  // Next X: 9-bit signed delta sign-extended to 17 bits; bit 16 of the sum
  // marks a negative result when clamping is compiled in.
  always_comb begin
    w_delta  = {{8{r_sign}}, r_sign, r_dx};
    w_sum    = {1'b0, o_mouse_x} + w_delta;
    w_next_x = w_sum[15:0];
    if (CLAMP_EN && w_sum[16]) begin
      w_next_x = 16'd0;
    end else if (CLAMP_EN && (w_sum[15:0] > X_MAX)) begin
      w_next_x = X_MAX;
    end else begin
      w_next_x = w_sum[15:0];
    end
  end

  // Frame state machine, packet assembly and output registers.
  always_ff @(posedge i_clock or posedge i_reset_) begin
    if (i_reset_) begin
      r_state          <= ST_IDLE;
      r_bit_cnt        <= 3'd0;
      r_shift          <= 8'd0;
      r_parity         <= 1'b0;
      r_byte_idx       <= 2'd0;
      r_btn            <= 1'b0;
      r_sign           <= 1'b0;
      r_ovf            <= 1'b0;
      r_dx             <= 8'd0;
      o_mouse_x        <= X_RESET;
      o_mouse_pressed_ <= 1'b1;
      o_packet_valid   <= 1'b0;
      o_frame_error    <= 1'b0;
    end else begin
      o_packet_valid <= 1'b0;
      o_frame_error  <= 1'b0;
      if (w_timeout) begin
        r_state       <= ST_IDLE;
        r_byte_idx    <= 2'd0;
        o_frame_error <= 1'b1;
      end else if (w_fall) begin
        case (r_state)
          ST_IDLE: begin
            if (!w_bit) begin
              r_state   <= ST_DATA;
              r_bit_cnt <= 3'd0;
            end else begin
              r_state <= ST_IDLE;
            end
          end
          ST_DATA: begin
            r_shift   <= {w_bit, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= ST_PARITY;
            else                   r_state <= ST_DATA;
          end
          ST_PARITY: begin
            r_parity <= w_bit;
            r_state  <= ST_STOP;
          end
          ST_STOP: begin
            r_state <= ST_IDLE;
            if (!w_bit || !odd_parity_ok(r_shift, r_parity)) begin
              o_frame_error <= 1'b1;
              r_byte_idx    <= 2'd0;
            end else begin
              case (r_byte_idx)
                2'd0: begin
                  // Sync bit clear: drop the byte and keep hunting for byte 0.
                  if (r_shift[3]) begin
                    r_btn      <= r_shift[0];
                    r_sign     <= r_shift[4];
                    r_ovf      <= r_shift[6];
                    r_byte_idx <= 2'd1;
                  end else begin
                    r_byte_idx <= 2'd0;
                  end
                end
                2'd1: begin
                  r_dx       <= r_shift;
                  r_byte_idx <= 2'd2;
                end
                2'd2: begin
                  o_mouse_pressed_ <= ~r_btn;
                  o_packet_valid   <= 1'b1;
                  r_byte_idx       <= 2'd0;
                  if (!r_ovf) o_mouse_x <= w_next_x;
                  else        o_mouse_x <= o_mouse_x;
                end
                default: r_byte_idx <= 2'd0;
              endcase
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end else begin
        r_state <= r_state;
      end
    end
  end

endmodule

// File: doc/mouse_tracker.md
# mouse_tracker

Front end that generates the `mouse_x` and `mouse_pressed_` inputs consumed by the counter sandbox. It receives a PS/2 mouse stream and assembles standard 3-byte packets. It then accumulates X movement into an absolute 16-bit position and tracks the left button. It sits between the board's PS/2 pins and the sandbox's mouse inputs, and runs in the system clock domain.

## Interface
- `X_MAX`, 639: upper bound of `mouse_x` when clamping is compiled in.
- `X_RESET`, 0: value of `mouse_x` after reset.
- `TIMEOUT`, 4096: system clocks without a `ps2_clk` falling edge before a partial frame is abandoned.
- `clock` input 1: system clock. This is the only clock.
- `reset_` input 1: asynchronous, active-high reset. It clears all state immediately.
- `ps2_clk` input 1: raw PS/2 clock, asynchronous to `clock`.
- `ps2_data` input 1: raw PS/2 data, asynchronous to `clock`.
- `mouse_x` output 16: absolute X position.
- `mouse_pressed_` output 1: left button, active-low (0 = held).
- `packet_valid` output 1: one-cycle pulse when a packet has been applied.
- `frame_error` output 1: one-cycle pulse on a parity, stop-bit or timeout error.

## Operation
- **Input synchronisation.** `ps2_clk` and `ps2_data` each pass through 2-flop synchronisers. A falling edge of synchronised `ps2_clk` is detected with a third flop, and `ps2_data` is sampled on that edge.
- **Frame state machine.**
  - IDLE: a sampled 0 (start bit) moves to DATA. A sampled 1 is ignored.
  - DATA: captures 8 bits, LSB first, using a 3-bit counter. After the 8th bit it moves to PARITY.
  - PARITY: samples the parity bit. Odd parity over data + parity is required. Then moves to STOP.
  - STOP: the sampled bit must be 1. Then returns to IDLE.
  - A parity or stop error raises `frame_error`, discards the byte and resets the packet byte index to 0.
- **Timeout.** A free-running idle counter reloads on every `ps2_clk` falling edge. If it reaches `TIMEOUT` while not in IDLE:
  - the machine returns to IDLE;
  - `frame_error` pulses;
  - the byte index resets to 0.
- **Packet assembly.** Byte index runs 0..2.
  - Byte 0, bit 3 must be 1 (sync bit). If it is 0, the byte is discarded and the index stays 0 (resync).
  - Byte 0 bit 0 = left button, bit 4 = X sign, bit 6 = X overflow.
  - Byte 1 = X delta, low 8 bits.
  - Byte 2 = Y delta; it is received and ignored.
- **Update on byte 2 accepted.**
  - `mouse_pressed_` is set to ~bit0.
  - If overflow = 0, the 9-bit two's-complement delta {sign, byte1} is sign-extended to 17 bits and added to {0, `mouse_x`}.
  - If overflow = 1, the delta is ignored and only the button updates.
  - `packet_valid` pulses.
- **Outputs.** `mouse_x` and `mouse_pressed_` hold between packets.

## Timing
- Reset values: `mouse_x` = `X_RESET`, `mouse_pressed_` = 1, `packet_valid` = 0, `frame_error` = 0. The state machine is in IDLE and the byte index is 0.
- Latency: a `ps2_clk` falling edge is sampled 3 `clock` cycles after it arrives at the pin.
- After the stop bit of byte 2 is sampled, `mouse_x`, `mouse_pressed_` and `packet_valid` update on the next `clock` edge.
- `packet_valid` and `frame_error` are never high in the same cycle.
- Reset asserted mid-frame or mid-packet clears everything asynchronously. The next start bit after reset is byte 0.
- Minimum supported `ps2_clk` period is 8 `clock` cycles.

## Configuration
- With `MOUSE_TRACKER_CLAMP_EN` defined: the 17-bit sum is saturated.
  - A negative result gives 0.
  - A result above `X_MAX` gives `X_MAX`.
- Without it: `mouse_x` takes the low 16 bits of the sum, wrapping modulo 2^16, and `X_MAX` is unused.

## Test plan
- Reset: assert `reset_` asynchronously mid-frame -> `mouse_x` = 0 and `mouse_pressed_` = 1 immediately. The next full packet is decoded correctly.
- Move right, pressed: packet 0x09, 0x0A, 0x00 -> `mouse_x` = 10, `mouse_pressed_` = 0, `packet_valid` high for exactly 1 cycle.
- Move left past 0: from `mouse_x` = 5, packet 0x18, 0xF6, 0x00 (delta -10) -> `mouse_x` = 0 with clamping, 0xFFFB without. `mouse_pressed_` = 1.
- Clamp high: from 630, packet 0x08, 0x14, 0x00 (+20) -> 639 with clamping, 650 without. Overflow packet 0x48, 0x14, 0x00 -> `mouse_x` unchanged, `packet_valid` pulses.
- Parity error in byte 1 -> `frame_error` pulses, no update. A following good packet 0x08, 0x03, 0x00 gives +3.
- Resync and timeout:
  - Byte 0x00 as byte 0 -> discarded. The following 0x08, 0x02, 0x00 gives +2.
  - Stop `ps2_clk` after 4 data bits for `TIMEOUT` cycles -> `frame_error` pulse, state returns to IDLE, and the next packet decodes correctly.
